// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage sitting directly after EX.
// Registers the EX->MEM bus, completes loads against a data SRAM whose read
// data returns with variable latency, extracts/extends load data and drives
// the MEM->WB and MEM->ID (forwarding) buses.
// Optional feature macro: MEM_LOAD_ALIGN_EN enables sub-word load extraction
// (lb/lbu/lh/lhu). When undefined every load returns the full 32-bit word.
//
// Handshake: data_sram_rvalid qualifies data_sram_rdata for one cycle; it is
// only consumed while a load sits in bus_r and the FSM is in IDLE or WAIT,
// and is ignored in DONE or when no load is present.
module mem_stage #(
    parameter int unsigned EX_TO_MEM_WD = 79,
    parameter int unsigned MEM_TO_WB_WD = 70
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_rvalid,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id_bus,
    output logic                    stallreq_for_mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [EX_TO_MEM_WD-1:0] bus_r;
    state_t                  state;
    state_t                  state_nxt;
    logic [31:0]             rdata_q;

    // Fields of the registered EX->MEM bus
    logic [2:0]  load_op;
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign load_op      = bus_r[78:76];
    assign ex_pc        = bus_r[75:44];
    assign data_ram_en  = bus_r[43];
    assign data_ram_wen = bus_r[42:39];
    assign sel_rf_res   = bus_r[38];
    assign rf_we        = bus_r[37];
    assign rf_waddr     = bus_r[36:32];
    assign ex_result    = bus_r[31:0];

    logic is_load;
    assign is_load = data_ram_en & (data_ram_wen == 4'b0000);

    // Only bits 3 (MEM) and 4 (WB) of the global stall vector matter here
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[2:0]};

    // Bus register: bubble when MEM stalls but WB moves, hold when both stall
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus_r <= '0;
        end else if (stall[3] && !stall[4]) begin
            bus_r <= '0;
        end else if (!stall[3]) begin
            bus_r <= ex_to_mem_bus;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (is_load) begin
                    if (data_sram_rvalid) begin
                        // zero-stall load only finishes here if MEM is free to move
                        state_nxt = stall[3] ? ST_DONE : ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_sram_rvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!stall[3]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: stall request, capture enable and the qualified rvalid
    logic capture_en;
    logic rvalid_eff;

    always_comb begin
        stallreq_for_mem = 1'b0;
        capture_en       = 1'b0;
        rvalid_eff       = 1'b0;
        case (state)
            ST_IDLE: begin
                stallreq_for_mem = is_load & ~data_sram_rvalid;
                capture_en       = is_load & data_sram_rvalid;
                rvalid_eff       = is_load & data_sram_rvalid;
            end
            ST_WAIT: begin
                stallreq_for_mem = ~data_sram_rvalid;
                capture_en       = data_sram_rvalid;
                rvalid_eff       = data_sram_rvalid;
            end
            default: begin
                stallreq_for_mem = 1'b0;
                capture_en       = 1'b0;
                rvalid_eff       = 1'b0;
            end
        endcase
    end

    // Captured load data, held across external stalls until the load retires
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (capture_en) begin
            rdata_q <= data_sram_rdata;
        end
    end

    // Load data selection and (optional) sub-word extraction
    logic [31:0] load_word;
    logic [31:0] load_data;

`ifdef MEM_LOAD_ALIGN_EN
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        load_word = rvalid_eff ? data_sram_rdata : rdata_q;
        case (ex_result[1:0])
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = ex_result[1] ? load_word[31:16] : load_word[15:0];
        case (load_op)
            3'b001:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b010:  load_data = {24'd0, load_byte};
            3'b011:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {16'd0, load_half};
            default: load_data = load_word;
        endcase
    end
`else
    logic unused_load_op;
    assign unused_load_op = ^load_op;

    always_comb begin
        load_word = rvalid_eff ? data_sram_rdata : rdata_q;
        load_data = load_word;
    end
`endif

    // Writeback data and output buses; forwarding hides unresolved load data
    logic [31:0] rf_wdata;

    always_comb begin
        rf_wdata      = sel_rf_res ? load_data : ex_result;
        mem_to_wb_bus = {ex_pc, rf_we, rf_waddr, rf_wdata};
        mem_to_id_bus = {rf_we & ~stallreq_for_mem, rf_waddr, rf_wdata};
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus for mem_stage with a scoreboard queue.
// Expected MEM->WB words are pushed when an instruction is issued; a monitor
// pops and compares whenever an instruction retires from MEM.
module tb_mem_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [5:0]  stall;
    logic [78:0] ex_to_mem_bus;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;
    logic        stallreq_for_mem;

    mem_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .stall            (stall),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rdata  (data_sram_rdata),
        .data_sram_rvalid (data_sram_rvalid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id_bus    (mem_to_id_bus),
        .stallreq_for_mem (stallreq_for_mem)
    );

    // ---------------- scoreboard state ----------------
    logic [69:0] exp_q[$];
    logic [69:0] mon_exp;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc,
                                       input logic en, input logic [3:0] wen,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {op, pc, en, wen, sel, we, wa, res};
    endfunction

    function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                       input logic [4:0] wa, input logic [31:0] data);
        return {pc, we, wa, data};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [78:0] nxt, input logic [5:0] stl,
                         input logic rv, input logic [31:0] rd);
        ex_to_mem_bus    = nxt;
        stall            = stl;
        data_sram_rvalid = rv;
        data_sram_rdata  = rd;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (resetn && !stall[3] && !stallreq_for_mem && mem_to_wb_bus[37]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got %h expected nothing", mem_to_wb_bus);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("wb_bus", mem_to_wb_bus, mon_exp);
                chk("id_bus", {32'd0, mem_to_id_bus}, {32'd0, mon_exp[37:0]});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [2:0]  t_op[9];
    logic [1:0]  t_addr[9];
    logic [31:0] t_exp[9];
    logic [78:0] ld;
    int          stall_cnt;

    initial begin
        t_op   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd3, 3'd4, 3'd5, 3'd0};
        t_addr = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd1, 2'd2};
`ifdef MEM_LOAD_ALIGN_EN
        t_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F,
                   32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
`else
        t_exp  = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                   32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
`endif

        // reset with a live instruction at the input: outputs must stay zero
        resetn = 1'b0;
        drive(mk(3'd0, 32'h2000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'h5555), 6'h00, 1'b1, 32'h1);
        repeat (3) tick;
        chk("reset_wb", mem_to_wb_bus, 70'd0);
        chk("reset_id", {32'd0, mem_to_id_bus}, 70'd0);
        chk("reset_stallreq", {69'd0, stallreq_for_mem}, 70'd0);

        // ALU op
        resetn = 1'b1;
        exp_q.push_back(wb(32'h1000, 1'b1, 5'd5, 32'h1234));
        drive(mk(3'd0, 32'h1000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'h1234), 6'h00, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h00, 1'b0, 32'h0);
        #1 chk("alu_stallreq", {69'd0, stallreq_for_mem}, 70'd0);
        tick;

        // lw, data in the entry cycle
        exp_q.push_back(wb(32'h1004, 1'b1, 5'd6, 32'hDEADBEEF));
        drive(mk(3'd0, 32'h1004, 1'b1, 4'd0, 1'b1, 1'b1, 5'd6, 32'h100), 6'h00, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h00, 1'b1, 32'hDEADBEEF);
        #1 chk("lw0_stallreq", {69'd0, stallreq_for_mem}, 70'd0);
        tick;

        // lw, data 3 cycles late; MEM and WB held while waiting
        exp_q.push_back(wb(32'h1008, 1'b1, 5'd7, 32'hCAFEF00D));
        drive(mk(3'd0, 32'h1008, 1'b1, 4'd0, 1'b1, 1'b1, 5'd7, 32'h104), 6'h00, 1'b0, 32'h0);
        tick;
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(79'd0, 6'h18, 1'b0, 32'h0BAD0BAD);
            #1;
            if (stallreq_for_mem) stall_cnt++;
            chk("fwd_we_in_stall", {69'd0, mem_to_id_bus[37]}, 70'd0);
            tick;
        end
        drive(79'd0, 6'h00, 1'b1, 32'hCAFEF00D);
        #1 chk("stallreq_on_rvalid", {69'd0, stallreq_for_mem}, 70'd0);
        tick;
        drive(79'd0, 6'h00, 1'b0, 32'h0);
        tick;
        chk("stall_cycles", 70'(stall_cnt), 70'd3);

        // back-to-back sub-word loads, rdata = 0x80FF7F01
        exp_q.push_back(wb(32'h1100, 1'b1, 5'd10, t_exp[0]));
        drive(mk(t_op[0], 32'h1100, 1'b1, 4'd0, 1'b1, 1'b1, 5'd10, {30'h80, t_addr[0]}),
              6'h00, 1'b0, 32'h0);
        tick;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                exp_q.push_back(wb(32'h1100 + 32'(4 * (i + 1)), 1'b1, 5'(10 + i + 1), t_exp[i + 1]));
                ld = mk(t_op[i + 1], 32'h1100 + 32'(4 * (i + 1)), 1'b1, 4'd0, 1'b1, 1'b1,
                        5'(10 + i + 1), {30'h80, t_addr[i + 1]});
            end else begin
                ld = 79'd0;
            end
            drive(ld, 6'h00, 1'b1, 32'h80FF7F01);
            tick;
        end

        // rvalid during an external stall: captured value survives rdata changes
        exp_q.push_back(wb(32'h1040, 1'b1, 5'd9, 32'h11223344));
        drive(mk(3'd0, 32'h1040, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h300), 6'h00, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h18, 1'b1, 32'h11223344);
        #1 chk("capture_stallreq", {69'd0, stallreq_for_mem}, 70'd0);
        tick;
        drive(79'd0, 6'h18, 1'b1, 32'hAAAAAAAA);
        #1 chk("done_stallreq", {69'd0, stallreq_for_mem}, 70'd0);
        tick;
        drive(79'd0, 6'h18, 1'b0, 32'h55555555);
        tick;
        drive(79'd0, 6'h00, 1'b1, 32'hFFFFFFFF);
        tick;

        // bubble insertion: MEM stalled, WB moving
        drive(mk(3'd0, 32'h1050, 1'b0, 4'd0, 1'b0, 1'b1, 5'd12, 32'hABCD), 6'h00, 1'b0, 32'h0);
        tick;
        drive(mk(3'd0, 32'h1054, 1'b0, 4'd0, 1'b0, 1'b1, 5'd13, 32'h7777), 6'h08, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h00, 1'b0, 32'h0);
        #1;
        chk("bubble_wb", mem_to_wb_bus, 70'd0);
        chk("bubble_id", {32'd0, mem_to_id_bus}, 70'd0);
        tick;

        // reset while waiting for load data, then a late rvalid
        drive(mk(3'd0, 32'h1060, 1'b1, 4'd0, 1'b1, 1'b1, 5'd13, 32'h400), 6'h00, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h18, 1'b0, 32'h0);
        #1 chk("wait_entry_stallreq", {69'd0, stallreq_for_mem}, 70'd1);
        tick;
        drive(79'd0, 6'h18, 1'b0, 32'h0);
        #1 chk("wait_stallreq", {69'd0, stallreq_for_mem}, 70'd1);
        tick;
        resetn = 1'b0;
        drive(79'd0, 6'h18, 1'b0, 32'h0);
        tick;
        resetn = 1'b1;
        drive(79'd0, 6'h00, 1'b1, 32'hDEAD0000);
        #1;
        chk("post_reset_wb", mem_to_wb_bus, 70'd0);
        chk("post_reset_id", {32'd0, mem_to_id_bus}, 70'd0);
        chk("post_reset_stallreq", {69'd0, stallreq_for_mem}, 70'd0);
        tick;

        // a fresh load after reset waits from IDLE
        exp_q.push_back(wb(32'h1070, 1'b1, 5'd14, 32'h76543210));
        drive(mk(3'd0, 32'h1070, 1'b1, 4'd0, 1'b1, 1'b1, 5'd14, 32'h500), 6'h00, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h18, 1'b0, 32'h0);
        #1 chk("fresh_load_stallreq", {69'd0, stallreq_for_mem}, 70'd1);
        tick;
        drive(79'd0, 6'h00, 1'b1, 32'h76543210);
        tick;
        drive(79'd0, 6'h00, 1'b0, 32'h0);
        tick;

        // trailing ALU op
        exp_q.push_back(wb(32'h1080, 1'b1, 5'd15, 32'h0F0F));
        drive(mk(3'd0, 32'h1080, 1'b0, 4'd0, 1'b0, 1'b1, 5'd15, 32'h0F0F), 6'h00, 1'b0, 32'h0);
        tick;
        drive(79'd0, 6'h00, 1'b0, 32'h0);
        tick;

        // bounded drain of the scoreboard
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick;
        chk("queue_drained", 70'(exp_q.size()), 70'd0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
